// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU command path: opcode map, sequencer
// state encoding and a small opcode classification helper.
package alu_ctrl_pkg;

    // ALU_Unit opcodes 0-13, plus two sequencer-only commands
    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_NAND = 4'd2;
    localparam logic [3:0] OP_NOR  = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_CMA  = 4'd5;
    localparam logic [3:0] OP_INC  = 4'd6;
    localparam logic [3:0] OP_DEC  = 4'd7;
    localparam logic [3:0] OP_ADD  = 4'd8;
    localparam logic [3:0] OP_SUB  = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;
    localparam logic [3:0] OP_SHR  = 4'd11;
    localparam logic [3:0] OP_SHL  = 4'd12;
    localparam logic [3:0] OP_ASR  = 4'd13;
    localparam logic [3:0] OP_LOAD = 4'd14;
    localparam logic [3:0] OP_READ = 4'd15;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    // Only ADD and SUB take the ALU carry into the Carry flag
    function automatic logic op_updates_carry(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Bundle of the command port, the ALU_Unit side-band and the response port
// of alu_cmd_sequencer. The sequencer uses the slave view; the surrounding
// logic (decoder, ALU_Unit, response sink) uses the master view.
//
// Handshake rule for both Cmd and Rsp: a transfer occurs on a rising clock
// edge where valid && ready are both 1. While valid is 1 and ready is 0 the
// source keeps valid high and its payload unchanged; ready may be asserted
// independently of valid.
interface alu_cmd_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             CmdValid;
    logic             CmdReady;
    logic [3:0]       CmdOp;
    logic [WIDTH-1:0] CmdData;

    logic [WIDTH-1:0] AluIn1;
    logic [WIDTH-1:0] AluIn2;
    logic [3:0]       AluOp;
    logic [WIDTH-1:0] AluResult;
    logic             AluCout;

    logic             RspValid;
    logic             RspReady;
    logic [WIDTH-1:0] RspData;
    logic             RspZero;
    logic             RspCarry;

    modport slave (
        input  CmdValid, CmdOp, CmdData, AluResult, AluCout, RspReady,
        output CmdReady, AluIn1, AluIn2, AluOp, RspValid, RspData, RspZero, RspCarry
    );

    modport master (
        output CmdValid, CmdOp, CmdData, AluResult, AluCout, RspReady,
        input  CmdReady, AluIn1, AluIn2, AluOp, RspValid, RspData, RspZero, RspCarry
    );

endinterface

// File: rtl/alu_cmd_sequencer.sv
// Command-level controller for the ALU_Unit datapath. Holds the accumulator
// (AC) and Carry flag, feeds AC and the latched command to the ALU, writes
// the ALU result back into AC and returns AC plus flags as a response.
// One command is in flight at a time; new commands wait on CmdReady.
module alu_cmd_sequencer
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int ALU_LATENCY = 0
) (
    input  logic               Clk,
    input  logic               Reset,
    alu_cmd_sequencer_if.slave bus,
    output state_t             o_dbg_state
);

    localparam int CNT_W = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY + 1) : 1;
    localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(ALU_LATENCY);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_ac;
    logic             r_carry;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_data;
    logic [CNT_W-1:0] r_wait_cnt;

    logic             w_accept;
    logic             w_capture;

    // Command accepted only while idle; capture on the last ALU wait cycle
    always_comb begin
        w_accept  = (r_state == S_IDLE) && bus.CmdValid;
        w_capture = 1'b0;
        if (ALU_LATENCY == 0) begin
            w_capture = (r_state == S_EXEC);
        end else begin
            w_capture = (r_state == S_WAIT) && (r_wait_cnt == CNT_W'(1));
        end
    end

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (bus.CmdValid) w_state_nxt = S_EXEC;
            S_EXEC: w_state_nxt = (ALU_LATENCY == 0) ? S_RESP : S_WAIT;
            S_WAIT: if (w_capture) w_state_nxt = S_RESP;
            S_RESP: if (bus.RspReady) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs: ALU is always fed from AC and the command latches, so its
    // inputs only move when AC is captured or a new command is accepted
    always_comb begin
        bus.CmdReady = (r_state == S_IDLE);
        bus.RspValid = (r_state == S_RESP);
        bus.RspData  = r_ac;
        bus.RspZero  = (r_ac == '0);
        bus.RspCarry = r_carry;
        bus.AluIn1   = r_ac;
        bus.AluIn2   = r_data;
        bus.AluOp    = r_op;
        o_dbg_state  = r_state;
    end

    // Datapath: command latches, ALU wait counter, AC and Carry write-back
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_ac       <= '0;
            r_carry    <= 1'b0;
            r_op       <= OP_AND;
            r_data     <= '0;
            r_wait_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_op   <= bus.CmdOp;
                r_data <= bus.CmdData;
            end

            if (r_state == S_EXEC) begin
                r_wait_cnt <= LAT_INIT;
            end else if (r_state == S_WAIT) begin
                r_wait_cnt <= r_wait_cnt - CNT_W'(1);
            end

            if (w_capture) begin
                case (r_op)
                    OP_LOAD: begin
                        r_ac    <= r_data;
                        r_carry <= 1'b0;
                    end
                    OP_READ: begin
                    end
                    default: begin
                        r_ac <= bus.AluResult;
                        if (op_updates_carry(r_op)) begin
                            r_carry <= bus.AluCout;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer: one instance with a combinational
// ALU (latency 0) and one with ALU_LATENCY=2, each beside an ALU_Unit model.
module tb_alu_cmd_sequencer;
    import alu_ctrl_pkg::*;

    logic   clk;
    logic   rst0;
    logic   rst2;
    state_t dbg0;
    state_t dbg2;
    int     checks;
    int     failures;

    alu_cmd_sequencer_if #(.WIDTH(8)) bus0 ();
    alu_cmd_sequencer_if #(.WIDTH(8)) bus2 ();

    alu_cmd_sequencer #(.WIDTH(8), .ALU_LATENCY(0)) dut0 (
        .Clk         (clk),
        .Reset       (rst0),
        .bus         (bus0.slave),
        .o_dbg_state (dbg0)
    );

    alu_cmd_sequencer #(.WIDTH(8), .ALU_LATENCY(2)) dut2 (
        .Clk         (clk),
        .Reset       (rst2),
        .bus         (bus2.slave),
        .o_dbg_state (dbg2)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU_Unit behaviour: {Cout, Result}; SUB reports a borrow in Cout
    function automatic logic [8:0] alu_model(input logic [3:0] op, input logic [7:0] a,
                                             input logic [7:0] b);
        logic [15:0] p;
        case (op)
            4'd0:  return {1'b0, a & b};
            4'd1:  return {1'b0, a | b};
            4'd2:  return {1'b0, ~(a & b)};
            4'd3:  return {1'b0, ~(a | b)};
            4'd4:  return {1'b0, a ^ b};
            4'd5:  return {1'b0, ~a};
            4'd6:  return {1'b0, a} + 9'd1;
            4'd7:  return {1'b0, a} - 9'd1;
            4'd8:  return {1'b0, a} + {1'b0, b};
            4'd9:  return {1'b0, a} - {1'b0, b};
            4'd10: begin
                p = 16'(a) * 16'(b);
                return {1'b0, p[7:0]};
            end
            4'd11: return {a[0], 1'b0, a[7:1]};
            4'd12: return {a[7], a[6:0], 1'b0};
            4'd13: return {a[0], a[7], a[7:1]};
            default: return 9'd0;
        endcase
    endfunction

    always_comb {bus0.AluCout, bus0.AluResult} = alu_model(bus0.AluOp, bus0.AluIn1, bus0.AluIn2);
    always_comb {bus2.AluCout, bus2.AluResult} = alu_model(bus2.AluOp, bus2.AluIn1, bus2.AluIn2);

    // driver: one full command on dut0, starting from IDLE, RspReady high
    task automatic do_cmd0(input logic [3:0] op, input logic [7:0] data, output logic [7:0] rd,
                           output logic rz, output logic rc, output int lat);
        int n;
        @(negedge clk);
        bus0.CmdOp    = op;
        bus0.CmdData  = data;
        bus0.CmdValid = 1'b1;
        @(posedge clk);
        #1 bus0.CmdValid = 1'b0;
        n   = 0;
        lat = -1;
        while (lat < 0 && n < 20) begin
            @(negedge clk);
            n++;
            if (bus0.RspValid) lat = n;
        end
        rd = bus0.RspData;
        rz = bus0.RspZero;
        rc = bus0.RspCarry;
        if (lat < 0) begin
            checks++;
            failures++;
            $display("FAIL rsp_timeout0 op=%0d got=no_rsp exp=rsp", op);
        end
        @(posedge clk);
        #1;
    endtask

    // driver: one full command on dut2, starting from IDLE, RspReady high
    task automatic do_cmd2(input logic [3:0] op, input logic [7:0] data, output logic [7:0] rd,
                           output logic rz, output logic rc, output int lat);
        int n;
        @(negedge clk);
        bus2.CmdOp    = op;
        bus2.CmdData  = data;
        bus2.CmdValid = 1'b1;
        @(posedge clk);
        #1 bus2.CmdValid = 1'b0;
        n   = 0;
        lat = -1;
        while (lat < 0 && n < 20) begin
            @(negedge clk);
            n++;
            if (bus2.RspValid) lat = n;
        end
        rd = bus2.RspData;
        rz = bus2.RspZero;
        rc = bus2.RspCarry;
        if (lat < 0) begin
            checks++;
            failures++;
            $display("FAIL rsp_timeout2 op=%0d got=no_rsp exp=rsp", op);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [22:0] got;
        rst0 = 1'b1;
        rst2 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst0 = 1'b0;
        rst2 = 1'b0;
        @(negedge clk);
        // {CmdReady, RspValid, AluOp, AluIn2, AluIn1, RspCarry}
        got = {bus0.CmdReady, bus0.RspValid, bus0.AluOp, bus0.AluIn2, bus0.AluIn1, bus0.RspCarry};
        checks++;
        if (got !== {1'b1, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0}) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=%h", got, {1'b1, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0});
        end
        checks++;
        if (dbg0 !== S_IDLE || dbg2 !== S_IDLE) begin
            failures++;
            $display("FAIL reset_state got=%0d/%0d exp=%0d", dbg0, dbg2, S_IDLE);
        end
        checks++;
        if (bus0.RspData !== 8'h00 || bus0.RspZero !== 1'b1) begin
            failures++;
            $display("FAIL reset_ac got=%h z=%b exp=00 z=1", bus0.RspData, bus0.RspZero);
        end
    endtask

    task automatic test_load();
        logic [7:0] rd;
        logic       rz;
        logic       rc;
        int         lat;
        do_cmd0(OP_LOAD, 8'h3C, rd, rz, rc, lat);
        checks++;
        if (lat !== 2) begin
            failures++;
            $display("FAIL load_latency got=%0d exp=2", lat);
        end
        checks++;
        if ({rd, rz, rc} !== {8'h3C, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL load_rsp got=%h z=%b c=%b exp=3c z=0 c=0", rd, rz, rc);
        end
    endtask

    typedef struct {
        logic [3:0] op;
        logic [7:0] data;
        logic [7:0] exp_d;
        logic       exp_z;
        logic       exp_c;
    } vec_t;

    vec_t vecs[23] = '{
        '{OP_LOAD, 8'hF0, 8'hF0, 1'b0, 1'b0},
        '{OP_ADD,  8'h20, 8'h10, 1'b0, 1'b1},
        '{OP_AND,  8'h00, 8'h00, 1'b1, 1'b1},
        '{OP_LOAD, 8'hFF, 8'hFF, 1'b0, 1'b0},
        '{OP_INC,  8'h00, 8'h00, 1'b1, 1'b0},
        '{OP_DEC,  8'h00, 8'hFF, 1'b0, 1'b0},
        '{OP_ASR,  8'h00, 8'hFF, 1'b0, 1'b0},
        '{OP_SHR,  8'h00, 8'h7F, 1'b0, 1'b0},
        '{OP_LOAD, 8'h12, 8'h12, 1'b0, 1'b0},
        '{OP_MUL,  8'h34, 8'hA8, 1'b0, 1'b0},
        '{OP_LOAD, 8'h90, 8'h90, 1'b0, 1'b0},
        '{OP_ADD,  8'h82, 8'h12, 1'b0, 1'b1},
        '{OP_MUL,  8'h34, 8'hA8, 1'b0, 1'b1},
        '{OP_LOAD, 8'h05, 8'h05, 1'b0, 1'b0},
        '{OP_SUB,  8'h07, 8'hFE, 1'b0, 1'b1},
        '{OP_READ, 8'h55, 8'hFE, 1'b0, 1'b1},
        '{OP_SUB,  8'h0E, 8'hF0, 1'b0, 1'b0},
        '{OP_LOAD, 8'hA5, 8'hA5, 1'b0, 1'b0},
        '{OP_XOR,  8'hFF, 8'h5A, 1'b0, 1'b0},
        '{OP_OR,   8'h81, 8'hDB, 1'b0, 1'b0},
        '{OP_NAND, 8'h0F, 8'hF4, 1'b0, 1'b0},
        '{OP_NOR,  8'h00, 8'h0B, 1'b0, 1'b0},
        '{OP_CMA,  8'h00, 8'hF4, 1'b0, 1'b0}
    };

    task automatic test_alu_ops();
        logic [7:0] rd;
        logic       rz;
        logic       rc;
        int         lat;
        for (int i = 0; i < 23; i++) begin
            do_cmd0(vecs[i].op, vecs[i].data, rd, rz, rc, lat);
            checks++;
            if (rd !== vecs[i].exp_d) begin
                failures++;
                $display("FAIL op_data[%0d] op=%0d got=%h exp=%h", i, vecs[i].op, rd, vecs[i].exp_d);
            end
            checks++;
            if ({rz, rc} !== {vecs[i].exp_z, vecs[i].exp_c}) begin
                failures++;
                $display("FAIL op_flags[%0d] op=%0d got z=%b c=%b exp z=%b c=%b", i, vecs[i].op,
                         rz, rc, vecs[i].exp_z, vecs[i].exp_c);
            end
        end
        do_cmd0(OP_SHL, 8'h00, rd, rz, rc, lat);
        checks++;
        if ({rd, rz, rc} !== {8'hE8, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL op_shl got=%h z=%b c=%b exp=e8 z=0 c=0", rd, rz, rc);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] rd;
        logic       rz;
        logic       rc;
        logic [9:0] got;
        int         lat;
        int         n;
        @(negedge clk);
        bus0.RspReady = 1'b0;
        bus0.CmdOp    = OP_LOAD;
        bus0.CmdData  = 8'h77;
        bus0.CmdValid = 1'b1;
        @(posedge clk);
        #1 bus0.CmdData = 8'h11;
        n = 0;
        while (!bus0.RspValid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!bus0.RspValid) begin
            failures++;
            $display("FAIL bp_rsp_timeout got=no_rsp exp=rsp");
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            got = {bus0.RspValid, bus0.CmdReady, bus0.RspData};
            checks++;
            if (got !== {1'b1, 1'b0, 8'h77}) begin
                failures++;
                $display("FAIL bp_hold[%0d] got=%h exp=%h", i, got, {1'b1, 1'b0, 8'h77});
            end
        end
        bus0.CmdValid = 1'b0;
        bus0.RspReady = 1'b1;
        @(posedge clk);
        #1;
        do_cmd0(OP_READ, 8'h00, rd, rz, rc, lat);
        checks++;
        if (rd !== 8'h77) begin
            failures++;
            $display("FAIL bp_no_second_accept got=%h exp=77", rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] rd;
        logic       rz;
        logic       rc;
        int         lat;
        int         accepts;
        do_cmd0(OP_LOAD, 8'h10, rd, rz, rc, lat);
        @(negedge clk);
        bus0.CmdOp    = OP_INC;
        bus0.CmdData  = 8'h00;
        bus0.CmdValid = 1'b1;
        accepts = 0;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clk);
            if (bus0.CmdReady) accepts++;
        end
        @(posedge clk);
        #1 bus0.CmdValid = 1'b0;
        checks++;
        if (accepts !== 4) begin
            failures++;
            $display("FAIL b2b_accepts got=%0d exp=4", accepts);
        end
        do_cmd0(OP_READ, 8'h00, rd, rz, rc, lat);
        checks++;
        if (rd !== 8'h14) begin
            failures++;
            $display("FAIL b2b_ac got=%h exp=14", rd);
        end
    endtask

    task automatic test_reset_mid_cmd();
        logic [7:0]  rd;
        logic        rz;
        logic        rc;
        logic [19:0] got;
        logic        seen;
        int          lat;
        do_cmd2(OP_LOAD, 8'h40, rd, rz, rc, lat);
        checks++;
        if (lat !== 4 || rd !== 8'h40) begin
            failures++;
            $display("FAIL lat2_load got lat=%0d d=%h exp lat=4 d=40", lat, rd);
        end
        @(negedge clk);
        bus2.CmdOp    = OP_ADD;
        bus2.CmdData  = 8'hC0;
        bus2.CmdValid = 1'b1;
        @(posedge clk);
        #1 bus2.CmdValid = 1'b0;
        @(negedge clk);
        got = {bus2.AluOp, bus2.AluIn1, bus2.AluIn2};
        checks++;
        if (dbg2 !== S_EXEC || got !== {OP_ADD, 8'h40, 8'hC0}) begin
            failures++;
            $display("FAIL lat2_exec got st=%0d alu=%h exp st=%0d alu=%h", dbg2, got, S_EXEC,
                     {OP_ADD, 8'h40, 8'hC0});
        end
        rst2 = 1'b1;
        @(posedge clk);
        #1 rst2 = 1'b0;
        @(negedge clk);
        checks++;
        if (dbg2 !== S_IDLE || bus2.CmdReady !== 1'b1 || bus2.RspData !== 8'h00 ||
            bus2.RspCarry !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset got st=%0d rdy=%b ac=%h c=%b exp st=0 rdy=1 ac=00 c=0", dbg2,
                     bus2.CmdReady, bus2.RspData, bus2.RspCarry);
        end
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (bus2.RspValid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_no_rsp got=%b exp=0", seen);
        end
        do_cmd2(OP_READ, 8'h00, rd, rz, rc, lat);
        checks++;
        if ({rd, rz, rc} !== {8'h00, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL mid_reset_read got=%h z=%b c=%b exp=00 z=1 c=0", rd, rz, rc);
        end
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst0          = 1'b1;
        rst2          = 1'b1;
        bus0.CmdValid = 1'b0;
        bus0.CmdOp    = 4'h0;
        bus0.CmdData  = 8'h00;
        bus0.RspReady = 1'b1;
        bus2.CmdValid = 1'b0;
        bus2.CmdOp    = 4'h0;
        bus2.CmdData  = 8'h00;
        bus2.RspReady = 1'b1;

        test_reset();
        test_load();
        test_alu_ops();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_cmd();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
